// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared constants and helpers for the character-LCD controller.
//   HD44780 command bytes, the DDRAM row-base lookup, a constant max
//   helper used to size counters, and the sequencer state type.
package lcd_pkg;

  localparam logic [7:0] FUNC_8B_2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] FUNC_8B_1L = 8'h30;  // 8-bit bus, 1 line, 5x8 font
  localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] ENTRY_INC  = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CLEAR      = 8'h01;  // clear display (slow)
  localparam logic [7:0] HOME       = 8'h02;  // cursor home (slow)
  localparam logic [7:0] SET_DDRAM  = 8'h80;  // OR with a DDRAM address

  typedef enum logic [3:0] {
    ST_INIT  = 4'd0,
    ST_FUNC  = 4'd1,
    ST_DISP  = 4'd2,
    ST_ENTRY = 4'd3,
    ST_CLEAR = 4'd4,
    ST_IDLE  = 4'd5,
    ST_ADDR  = 4'd6,
    ST_CHARS = 4'd7,
    ST_HOME  = 4'd8
  } lcdState_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // DDRAM start address of each display row (4-row parts interleave rows).
  function automatic logic [7:0] rowbase(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      2'd3:    return 8'h54;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// lcd_text_ctrl_if
//   Pin bundle of the HD44780 parallel bus.
//   master: the controller driving the pins; slave: the panel / an observer.
//   LCD_E enable strobe, LCD_RS 0=command 1=data, LCD_RW 0=write,
//   LCD_DATA 8-bit data bus.
interface lcd_text_ctrl_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_DATA);
  modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_DATA);
endinterface

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer
//   Runs one bus transaction per byte: SETUP (1 cycle, E=0), STROBE (E=1 for
//   E_PW cycles), HOLD (1 cycle, E=0), WAIT (CMD_WAIT or CLR_WAIT cycles).
//   RS/DATA are loaded at SETUP and held until the next byte is taken.
// Ports
//   CLK, RESETN        clock, synchronous active-high reset
//   start              a byte is offered (level; held until done)
//   rs, data, longWait byte to send; longWait selects CLR_WAIT
//   done               combinational pulse: the offered byte was taken this cycle
//   busy               a transaction is still in progress
//   lcdE/lcdRs/lcdData registered pin drivers
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int E_PW     = 1,
  parameter int CMD_WAIT = 30,
  parameter int CLR_WAIT = 50
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       longWait,
  output logic       done,
  output logic       busy,
  output logic       lcdE,
  output logic       lcdRs,
  output logic [7:0] lcdData
);

  localparam int W = $clog2(maxOf(maxOf(E_PW, CMD_WAIT), CLR_WAIT) + 1);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_SETUP  = 3'd1;
  localparam logic [2:0] PH_STROBE = 3'd2;
  localparam logic [2:0] PH_HOLD   = 3'd3;
  localparam logic [2:0] PH_WAIT   = 3'd4;

  logic [2:0]   phaseR;
  logic [W-1:0] cntR;
  logic         longR;
  logic         eR;
  logic         rsR;
  logic [7:0]   dataR;
  logic         free;

  // The last WAIT cycle counts as free, so consecutive bytes run back-to-back.
  assign free    = (phaseR == PH_IDLE) || ((phaseR == PH_WAIT) && (cntR == '0));
  assign done    = start && free;
  assign busy    = (phaseR != PH_IDLE);
  assign lcdE    = eR;
  assign lcdRs   = rsR;
  assign lcdData = dataR;

  // Transaction phase sequencer and pin registers
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      phaseR <= PH_IDLE;
      cntR   <= '0;
      longR  <= 1'b0;
      eR     <= 1'b0;
      rsR    <= 1'b0;
      dataR  <= 8'h00;
    end else if (done) begin
      phaseR <= PH_SETUP;
      rsR    <= rs;
      dataR  <= data;
      longR  <= longWait;
      eR     <= 1'b0;
    end else begin
      case (phaseR)
        PH_SETUP: begin
          phaseR <= PH_STROBE;
          eR     <= 1'b1;
          cntR   <= W'(E_PW - 1);
        end
        PH_STROBE: begin
          if (cntR == '0) begin
            eR     <= 1'b0;
            phaseR <= PH_HOLD;
          end else begin
            cntR <= cntR - W'(1);
          end
        end
        PH_HOLD: begin
          phaseR <= PH_WAIT;
          cntR   <= longR ? W'(CLR_WAIT - 1) : W'(CMD_WAIT - 1);
        end
        PH_WAIT: begin
          if (cntR == '0) begin
            phaseR <= PH_IDLE;
          end else begin
            cntR <= cntR - W'(1);
          end
        end
        PH_IDLE: begin
          phaseR <= PH_IDLE;
        end
        default: begin
          phaseR <= PH_IDLE;
          eR     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl
//   HD44780-class character-LCD controller. After reset it runs the init
//   sequence (FUNCTION_SET, DISPLAY_ON, ENTRY_MODE, CLEAR), then on request
//   captures a ROWS x COLS frame into a shadow copy and writes it row by row
//   (DDRAM address, COLS data bytes), finishing with HOME.
// Ports
//   CLK          system clock
//   RESETN       synchronous, active-high reset
//   FRAME        characters, row r col c at [(r*COLS+c)*8 +: 8]
//   UPDATE_REQ   request a frame write
//   UPDATE_ACK   1-cycle pulse: FRAME captured
//   BUSY         init or frame write in progress
//   lcd          LCD pin bundle (master side)
// Configuration
//   LCD_AUTO_REFRESH_EN: when defined, IDLE also rewrites the frame 1000
//   cycles after the bus went idle, without pulsing UPDATE_ACK.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int COLS      = 16,
  parameter int ROWS      = 2,
  parameter int INIT_WAIT = 70,
  parameter int CMD_WAIT  = 30,
  parameter int CLR_WAIT  = 50,
  parameter int E_PW      = 1
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [ROWS*COLS*8-1:0] FRAME,
  input  logic                   UPDATE_REQ,
  output logic                   UPDATE_ACK,
  output logic                   BUSY,
  lcd_text_ctrl_if.master        lcd
);

  localparam int CNT_W = $clog2(maxOf(maxOf(INIT_WAIT, CLR_WAIT), COLS) + 1);

  lcdState_t              stateR;
  logic [CNT_W-1:0]       initCntR;
  logic [CNT_W-1:0]       colR;
  logic [1:0]             rowR;
  logic [ROWS*COLS*8-1:0] shadowR;
  logic                   ackR;
  logic                   busyR;
  logic                   rwR;

  logic                   wrStart;
  logic                   wrRs;
  logic [7:0]             wrData;
  logic                   wrLong;
  logic                   wrDone;
  logic                   wrBusy;
  logic                   wrE;
  logic                   wrRsOut;
  logic [7:0]             wrDataOut;

  int                     charBase;
  logic [ROWS*COLS*8-1:0] charShift;
  logic [7:0]             charByte;
  logic                   idleNow;
  logic                   acceptReq;
  logic                   refreshDue;

  // Idle means the sequencer is parked and the last byte's wait has elapsed,
  // so a new frame can never overlap the CLEAR or HOME wait.
  assign idleNow   = (stateR == ST_IDLE) && !wrBusy;
  assign acceptReq = idleNow && !busyR && UPDATE_REQ;

  assign UPDATE_ACK   = ackR;
  assign BUSY         = busyR;
  assign lcd.LCD_E    = wrE;
  assign lcd.LCD_RS   = wrRsOut;
  assign lcd.LCD_DATA = wrDataOut;
  assign lcd.LCD_RW   = rwR;

  // Current character out of the shadow frame
  always_comb begin
    charBase  = (int'(rowR) * COLS + int'(colR)) * 8;
    charShift = shadowR >> charBase;
    charByte  = charShift[7:0];
  end

  // Byte the sequencer offers to the writer in each state
  always_comb begin
    wrStart = 1'b0;
    wrRs    = 1'b0;
    wrData  = 8'h00;
    wrLong  = 1'b0;
    case (stateR)
      ST_FUNC:  begin wrStart = 1'b1; wrData = (ROWS > 1) ? FUNC_8B_2L : FUNC_8B_1L; end
      ST_DISP:  begin wrStart = 1'b1; wrData = DISP_ON;   end
      ST_ENTRY: begin wrStart = 1'b1; wrData = ENTRY_INC; end
      ST_CLEAR: begin wrStart = 1'b1; wrData = CLEAR; wrLong = 1'b1; end
      ST_ADDR:  begin wrStart = 1'b1; wrData = SET_DDRAM | rowbase(rowR); end
      ST_CHARS: begin wrStart = 1'b1; wrRs = 1'b1; wrData = charByte; end
      ST_HOME:  begin wrStart = 1'b1; wrData = HOME; wrLong = 1'b1; end
      default:  begin wrStart = 1'b0; end
    endcase
  end

`ifdef LCD_AUTO_REFRESH_EN
  localparam int REFRESH_PERIOD = 1000;
  localparam int REF_W = $clog2(REFRESH_PERIOD + 1);
  logic [REF_W-1:0] refCntR;

  // Cycles spent idle since the bus last went quiet; saturates at the period
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      refCntR <= '0;
    end else if (!idleNow) begin
      refCntR <= '0;
    end else if (refCntR != REF_W'(REFRESH_PERIOD - 1)) begin
      refCntR <= refCntR + REF_W'(1);
    end else begin
      refCntR <= refCntR;
    end
  end

  assign refreshDue = idleNow && !busyR && (refCntR == REF_W'(REFRESH_PERIOD - 1));
`else
  assign refreshDue = 1'b0;
`endif

  // Top-level sequencer: init chain, request handshake, frame walk
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      stateR   <= ST_INIT;
      initCntR <= '0;
      colR     <= '0;
      rowR     <= 2'd0;
      shadowR  <= '0;
      ackR     <= 1'b0;
      busyR    <= 1'b1;
      rwR      <= 1'b0;
    end else begin
      ackR  <= 1'b0;
      busyR <= !idleNow;
      rwR   <= 1'b0;
      case (stateR)
        ST_INIT: begin
          if (initCntR == CNT_W'(INIT_WAIT - 1)) begin
            stateR <= ST_FUNC;
          end else begin
            initCntR <= initCntR + CNT_W'(1);
          end
        end
        ST_FUNC:  if (wrDone) stateR <= ST_DISP;  else stateR <= ST_FUNC;
        ST_DISP:  if (wrDone) stateR <= ST_ENTRY; else stateR <= ST_DISP;
        ST_ENTRY: if (wrDone) stateR <= ST_CLEAR; else stateR <= ST_ENTRY;
        ST_CLEAR: if (wrDone) stateR <= ST_IDLE;  else stateR <= ST_CLEAR;
        ST_IDLE: begin
          // A pending request takes priority over a refresh due the same cycle.
          if (acceptReq) begin
            ackR    <= 1'b1;
            busyR   <= 1'b1;
            shadowR <= FRAME;
            rowR    <= 2'd0;
            colR    <= '0;
            stateR  <= ST_ADDR;
          end else if (refreshDue) begin
            busyR   <= 1'b1;
            shadowR <= FRAME;
            rowR    <= 2'd0;
            colR    <= '0;
            stateR  <= ST_ADDR;
          end else begin
            stateR <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (wrDone) begin
            colR   <= '0;
            stateR <= ST_CHARS;
          end else begin
            stateR <= ST_ADDR;
          end
        end
        ST_CHARS: begin
          if (wrDone) begin
            if (colR == CNT_W'(COLS - 1)) begin
              if (rowR == 2'(ROWS - 1)) begin
                stateR <= ST_HOME;
              end else begin
                rowR   <= rowR + 2'd1;
                stateR <= ST_ADDR;
              end
            end else begin
              colR <= colR + CNT_W'(1);
            end
          end else begin
            stateR <= ST_CHARS;
          end
        end
        ST_HOME:  if (wrDone) stateR <= ST_IDLE; else stateR <= ST_HOME;
        default:  stateR <= ST_INIT;
      endcase
    end
  end

  lcd_byte_writer #(
    .E_PW     (E_PW),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) uWriter (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .start    (wrStart),
    .rs       (wrRs),
    .data     (wrData),
    .longWait (wrLong),
    .done     (wrDone),
    .busy     (wrBusy),
    .lcdE     (wrE),
    .lcdRs    (wrRsOut),
    .lcdData  (wrDataOut)
  );

endmodule
